alu_seq_divider: RTL and testbench
==================================

Name: alu_seq_divider

Overview:
- Multi-cycle unsigned divider (RISC-V DIVU/REMU semantics) that acts as the initiator side of the ALU interface.
- It drives the ALU's sel/a/b inputs and consumes its out/zero outputs, one restoring-division step per cycle, instead of carrying its own subtractor.
- Sits beside the datapath; the top level instantiates a second ALU at width N+1 and connects it to the alu_* ports.
- The CPU issues start/operands and waits for done.

Parameters:
- N, 32, operand/result width; the attached ALU is instantiated with width N+1.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; accepted only when busy=0
- dividend  in  N  sampled on the accepted start
- divisor  in  N  sampled on the accepted start
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse; results valid from this cycle
- quotient  out  N  registered, held until the next accepted start
- remainder  out  N  registered, held until the next accepted start
- div_by_zero  out  1  registered, valid with done, held with results
- alu_sel  out  4  ALU opcode: 0010 add, 0110 sub, 0000 and, 0001 or
- alu_a  out  N+1  ALU operand a
- alu_b  out  N+1  ALU operand b
- alu_out  in  N+1  ALU result (combinational from alu_sel/a/b)
- alu_zero  in  1  ALU zero flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal rem/q/divisor registers and counter cleared.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE, CHECK, DIV, FIN.
- IDLE:
  - ALU drive: alu_sel=0000, alu_a=0, alu_b=0.
  - On start: latch q<=dividend, d<=divisor, rem<=0, cnt<=0; go to CHECK.
- CHECK (busy=1):
  - ALU drive: alu_sel=0001 (OR), alu_a=0, alu_b={1'b0,d}.
  - If alu_zero=1: quotient<=all ones, remainder<=q (the dividend), div_by_zero<=1; go to FIN.
  - Otherwise: div_by_zero<=0; go to DIV.
- DIV (busy=1), N cycles:
  - ALU drive: alu_sel=0110 (SUB), alu_a={rem,q[N-1]}, alu_b={1'b0,d}.
  - If alu_out[N]=0: rem<=alu_out[N-1:0]. Otherwise rem<={rem[N-2:0],q[N-1]}.
  - Always q<={q[N-2:0],~alu_out[N]}; cnt<=cnt+1.
  - When cnt=N-1 (last step): go to FIN, loading quotient/remainder from the next q/rem values.
  - alu_out[N] is a valid borrow because a<2d, so the N+1-bit difference never overflows.
- FIN:
  - done=1 and busy=0 for exactly one cycle; return to IDLE.
  - start asserted during FIN is accepted (busy=0), giving back-to-back operation.
- start while busy=1 is ignored; operands are not re-sampled.
- Latency from the accepting edge E:
  - Normal division: done high in cycle E+N+2 (34 cycles for N=32).
  - Divide by zero: done high in cycle E+2.
- Outputs are all registered except alu_*, which are a combinational decode of state/registers (no glitch requirement).

Decomposition:
- Shared package holds the ALU opcode constants (ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110) for reuse by the ALU control decoder, and the state encoding localparams.
- No sub-module inside the divider.
- The ALU is instantiated next to it (width N+1) by the enclosing level; the bench instantiates the same pair.

Test Plan:
- N=32, start with 100/7 -> done at E+34; quotient=14, remainder=2, div_by_zero=0; busy high cycles E+1..E+33.
- 7/0 -> done at E+2; quotient=FFFFFFFF, remainder=7, div_by_zero=1; alu_sel=0001 seen in CHECK, 0110 never issued.
- FFFFFFFF/1 -> quotient=FFFFFFFF, remainder=0. Then 5/9 started in the FIN cycle -> accepted; quotient=0, remainder=5, done 34 cycles later.
- Start 1000/10, then pulse start with 3/3 at E+5 -> ignored; final quotient=100, remainder=0.
- Start 1000/10, drop rst_n at E+10 -> all outputs 0 immediately; no done pulse. After release, start 9/2 -> quotient=4, remainder=1.
- Randomized 200 operand pairs vs reference model (a/b, a%b, b=0 case) -> exact match and exactly one done pulse per accepted start.

Source files
------------

// File: rtl/alu_seq_divider_pkg.sv
// Shared definitions for the sequential divider: ALU opcodes and FSM state encoding.
package alu_seq_divider_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_CHECK_ENC = 2'd1;
  localparam logic [1:0] ST_DIV_ENC   = 2'd2;
  localparam logic [1:0] ST_FIN_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_CHECK = ST_CHECK_ENC,
    ST_DIV   = ST_DIV_ENC,
    ST_FIN   = ST_FIN_ENC
  } div_state_e;

endpackage

// File: rtl/alu_seq_divider_if.sv
// CPU-side request/result bundle of the divider, plus the FSM state for observation.
interface alu_seq_divider_if
  import alu_seq_divider_pkg::*;
#(
  parameter int N = 32
) ();
  // Handshake: start is taken on a rising edge only while busy=0; done pulses
  // one cycle with quotient/remainder/div_by_zero valid, and they hold until
  // the next accepted start. start while busy=1 is dropped.
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  div_state_e   state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, state
  );
endinterface

// File: rtl/alu_seq_divider_alu.sv
// Small combinational ALU (and/or/add/sub) paired with the divider at width N+1.
module alu_seq_divider_alu
  import alu_seq_divider_pkg::*;
#(
  parameter int W = 33
) (
  input  logic [3:0]   sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] out,
  output logic         zero
);

  always_comb begin
    out = '0;
    case (sel)
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_ADD: out = a + b;
      ALU_SUB: out = a - b;
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: rtl/alu_seq_divider.sv
// Restoring unsigned divider (DIVU/REMU) that borrows an external N+1-bit ALU
// for its zero test and per-step trial subtraction.
module alu_seq_divider
  import alu_seq_divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_seq_divider_if.slave     bus,
  output logic [3:0]           alu_sel,
  output logic [N:0]           alu_a,
  output logic [N:0]           alu_b,
  input  logic [N:0]           alu_out,
  input  logic                 alu_zero
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  div_state_e       state, state_next;
  logic [N-1:0]     rem_r, q_r, d_r;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     rem_step, q_step;
  logic             accept;

  assign bus.state = state;
  assign accept    = bus.start && ((state == ST_IDLE) || (state == ST_FIN));

  // alu_out[N] is the borrow of {rem,q_msb} - d; it cannot overflow since rem < d.
  assign rem_step = alu_out[N] ? {rem_r[N-2:0], q_r[N-1]} : alu_out[N-1:0];
  assign q_step   = {q_r[N-2:0], ~alu_out[N]};

  always_comb begin
    state_next = state;
    alu_sel    = ALU_AND;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        alu_sel    = ALU_OR;
        alu_b      = {1'b0, d_r};
        state_next = alu_zero ? ST_FIN : ST_DIV;
      end
      ST_DIV: begin
        alu_sel = ALU_SUB;
        alu_a   = {rem_r, q_r[N-1]};
        alu_b   = {1'b0, d_r};
        if (cnt == CNT_LAST) state_next = ST_FIN;
      end
      ST_FIN: begin
        state_next = accept ? ST_CHECK : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      rem_r           <= '0;
      q_r             <= '0;
      d_r             <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      state    <= state_next;
      bus.busy <= (state_next == ST_CHECK) || (state_next == ST_DIV);
      bus.done <= (state_next == ST_FIN);
      if (accept) begin
        q_r   <= bus.dividend;
        d_r   <= bus.divisor;
        rem_r <= '0;
        cnt   <= '0;
      end
      if (state == ST_CHECK) begin
        if (alu_zero) begin
          bus.quotient    <= '1;
          bus.remainder   <= q_r;
          bus.div_by_zero <= 1'b1;
        end else begin
          bus.div_by_zero <= 1'b0;
        end
      end
      if (state == ST_DIV) begin
        rem_r <= rem_step;
        q_r   <= q_step;
        cnt   <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          bus.quotient  <= q_step;
          bus.remainder <= rem_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Bench for alu_seq_divider paired with its N+1-bit ALU: directed table, corner sequences, random pairs.
module tb_alu_seq_divider;
  import alu_seq_divider_pkg::*;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic [3:0]   alu_sel;
  logic [N:0]   alu_a, alu_b, alu_out;
  logic         alu_zero;

  alu_seq_divider_if #(.N(N)) bus ();

  alu_seq_divider #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_sel  (alu_sel),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_out  (alu_out),
    .alu_zero (alu_zero)
  );

  alu_seq_divider_alu #(.W(N + 1)) alu (
    .sel  (alu_sel),
    .a    (alu_a),
    .b    (alu_b),
    .out  (alu_out),
    .zero (alu_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_expect_done = 0;

  logic [2*N:0] exp_q[$];

  always @(negedge clk) if (bus.done) n_done++;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*N:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == 0) return {{N{1'b1}}, a, 1'b1};
    return {a / b, a % b, 1'b0};
  endfunction

  // driver: called just after a negedge; returns 1ns after the accepting edge
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N:0] exp);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // waits for done (k-th negedge after the accept edge is cycle E+k) and scores the result
  task automatic wait_check(input int exp_lat, input int inject_at);
    logic [2*N:0] exp;
    logic [3:0]   sel_k1;
    bit           got, seen_sub, busy_bad;
    int           lat;
    got = 0; seen_sub = 0; busy_bad = 0; lat = 0; sel_k1 = 4'hx;
    exp = exp_q.pop_front();
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) sel_k1 = alu_sel;
      if (bus.done) begin
        got = 1;
        lat = k;
        break;
      end
      if (!bus.busy) busy_bad = 1;
      if (alu_sel == ALU_SUB) seen_sub = 1;
      if (inject_at > 0) begin
        if (k == inject_at) begin
          bus.start = 1'b1; bus.dividend = 3; bus.divisor = 3;
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    n_expect_done++;
    check("done_seen", got, 1);
    if (got) begin
      check("latency", lat, exp_lat);
      check("busy_at_done", bus.busy, 0);
      check("quotient", bus.quotient, exp[2*N:N+1]);
      check("remainder", bus.remainder, exp[N:1]);
      check("div_by_zero", bus.div_by_zero, exp[0]);
    end
    check("busy_profile", busy_bad, 0);
    check("check_sel_or", sel_k1, ALU_OR);
    if (exp[0]) check("no_sub_on_zero", seen_sub, 0);
  endtask

  initial begin
    int snap;
    logic [N-1:0] ra, rb;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,   1'b0, 34};
    vecs[1]  = '{32'd7,          32'd0,          32'hFFFFFFFF,   32'd7,   1'b1, 2};
    vecs[2]  = '{32'd12345678,   32'd1000,       32'd12345,      32'd678, 1'b0, 34};
    vecs[3]  = '{32'h80000000,   32'd2,          32'h40000000,   32'd0,   1'b0, 34};
    vecs[4]  = '{32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF,   1'b0, 34};
    vecs[5]  = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,   1'b1, 2};
    vecs[6]  = '{32'd0,          32'd5,          32'd0,          32'd0,   1'b0, 34};
    vecs[7]  = '{32'd3,          32'd3,          32'd1,          32'd0,   1'b0, 34};
    vecs[8]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,   1'b0, 34};
    vecs[9]  = '{32'd6,          32'hFFFFFFFF,   32'd0,          32'd6,   1'b0, 34};
    vecs[10] = '{32'd9,          32'd2,          32'd4,          32'd1,   1'b0, 34};
    vecs[11] = '{32'd1000,       32'd10,         32'd100,        32'd0,   1'b0, 34};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    check("rst_alu_sel", alu_sel, ALU_AND);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].a, vecs[i].b, {vecs[i].q, vecs[i].r, vecs[i].dbz});
      wait_check(vecs[i].lat, 0);
      @(negedge clk);
    end

    // back-to-back: second start presented in the FIN cycle
    start_op(32'hFFFFFFFF, 32'd1, {32'hFFFFFFFF, 32'd0, 1'b0});
    wait_check(34, 0);
    start_op(32'd5, 32'd9, {32'd0, 32'd5, 1'b0});
    wait_check(34, 0);
    @(negedge clk);

    // start while busy is ignored
    start_op(32'd1000, 32'd10, {32'd100, 32'd0, 1'b0});
    wait_check(34, 4);
    @(negedge clk);

    // reset mid-operation aborts with no done
    start_op(32'd1000, 32'd10, {32'd100, 32'd0, 1'b0});
    void'(exp_q.pop_front());
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_dbz", bus.div_by_zero, 0);
    check("abort_alu_sel", alu_sel, ALU_AND);
    snap = n_done;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", n_done - snap, 0);
    start_op(32'd9, 32'd2, {32'd4, 32'd1, 1'b0});
    wait_check(34, 0);
    @(negedge clk);

    // random pairs against the reference model
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = N'($urandom_range(1, 20));
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      start_op(ra, rb, ref_div(ra, rb));
      wait_check((rb == 0) ? 2 : 34, 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("done_pulse_count", n_done, n_expect_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
